// File: rtl/gpu_sched_pkg.sv
// Shared types and defaults for the warp dispatcher slice.
//   warp_status_t    : per-warp lifecycle (INACTIVE, READY, WAIT_MEM, RETIRED)
//   dispatch_state_t : issue FSM states (IDLE, SELECT, FETCH, EXECUTE, DONE)
//   warps_needed()   : ceil(thread_count / threads_per_warp), capped at the slot count
// Optional build macro used by this slice: WARP_DISPATCHER_PERF_EN (performance counters).
package gpu_sched_pkg;

    localparam int DEF_MAX_WARPS        = 4;
    localparam int DEF_THREADS_PER_WARP = 4;
    localparam int DEF_PC_BITS          = 8;
    localparam int THREAD_COUNT_BITS    = 8;

    typedef enum logic [1:0] {
        INACTIVE = 2'd0,
        READY    = 2'd1,
        WAIT_MEM = 2'd2,
        RETIRED  = 2'd3
    } warp_status_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        FETCH   = 3'd2,
        EXECUTE = 3'd3,
        DONE    = 3'd4
    } dispatch_state_t;

    function automatic int unsigned warps_needed(input int unsigned tc,
                                                 input int unsigned tpw,
                                                 input int unsigned max_w);
        int unsigned n;
        n = (tc + tpw - 1) / tpw;
        return (n > max_w) ? max_w : n;
    endfunction

endpackage

// File: rtl/warp_dispatcher_if.sv
// Handshake bundle between the warp dispatcher and the rest of the core.
//   master modport : dispatcher side (drives done/fetch/warp id/mask/perf)
//   slave modport  : core side (drives start/thread_count/fetch_ready/exec/mem responses)
interface warp_dispatcher_if #(
    parameter int PC_BITS          = 8,
    parameter int THREADS_PER_WARP = 4,
    parameter int WARP_ID_BITS     = 2
);
    import gpu_sched_pkg::*;

    logic                          start;
    logic [THREAD_COUNT_BITS-1:0]  thread_count;
    logic                          done;
    logic                          fetch_valid;
    logic [PC_BITS-1:0]            fetch_pc;
    logic                          fetch_ready;
    logic [WARP_ID_BITS-1:0]       current_warp_id;
    logic [THREADS_PER_WARP-1:0]   thread_mask;
    logic                          exec_valid;
    logic [PC_BITS-1:0]            exec_next_pc;
    logic                          decoded_done;
    logic                          decoded_mem_read_enable;
    logic                          decoded_mem_write_enable;
    logic                          mem_resp_valid;
    logic [WARP_ID_BITS-1:0]       mem_resp_warp_id;
    logic [31:0]                   perf_issue_count;
    logic [31:0]                   perf_stall_count;

    modport master (
        input  start, thread_count, fetch_ready, exec_valid, exec_next_pc,
               decoded_done, decoded_mem_read_enable, decoded_mem_write_enable,
               mem_resp_valid, mem_resp_warp_id,
        output done, fetch_valid, fetch_pc, current_warp_id, thread_mask,
               perf_issue_count, perf_stall_count
    );

    modport slave (
        output start, thread_count, fetch_ready, exec_valid, exec_next_pc,
               decoded_done, decoded_mem_read_enable, decoded_mem_write_enable,
               mem_resp_valid, mem_resp_warp_id,
        input  done, fetch_valid, fetch_pc, current_warp_id, thread_mask,
               perf_issue_count, perf_stall_count
    );

endinterface

// File: rtl/warp_rr_arbiter.sv
// Combinational round-robin picker.
//   i_req   : one request bit per warp (warp is READY)
//   i_ptr   : first index to consider; search wraps around
//   o_grant : index of the first requesting warp at or after i_ptr
//   o_valid : at least one request present
module warp_rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    output logic [IDW-1:0] o_grant,
    output logic           o_valid
);

    always_comb begin
        int idx;
        o_grant = '0;
        o_valid = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(i_ptr) + k) % N;
            if (!o_valid && i_req[idx]) begin
                o_valid = 1'b1;
                o_grant = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/warp_dispatcher.sv
// Multi-warp issue controller: tracks per-warp PC/status, picks the next READY warp
// round-robin, sequences fetch -> execute, and parks warps on memory ops.
// Ports:
//   clk   : core clock
//   reset : synchronous, active-high
//   bus   : warp_dispatcher_if.master (start/thread_count in, fetch handshake,
//           execute completion, memory responses, done, perf counters)
// Build option: WARP_DISPATCHER_PERF_EN enables saturating issue/stall counters;
// without it both perf outputs are constant 0.
module warp_dispatcher
    import gpu_sched_pkg::*;
#(
    parameter int MAX_WARPS_PER_CORE = DEF_MAX_WARPS,
    parameter int THREADS_PER_WARP   = DEF_THREADS_PER_WARP,
    parameter int PC_BITS            = DEF_PC_BITS,
    parameter int WARP_ID_BITS       = $clog2(MAX_WARPS_PER_CORE)
) (
    input  logic                clk,
    input  logic                reset,
    warp_dispatcher_if.master   bus
);

    dispatch_state_t             r_state, w_state_next;
    warp_status_t                r_status [MAX_WARPS_PER_CORE];
    logic [PC_BITS-1:0]          r_pc     [MAX_WARPS_PER_CORE];
    logic [WARP_ID_BITS-1:0]     r_rr_ptr;
    logic [WARP_ID_BITS-1:0]     r_cur_warp;
    logic [THREADS_PER_WARP-1:0] r_thread_mask;
    logic [THREAD_COUNT_BITS-1:0] r_thread_count;

    logic [MAX_WARPS_PER_CORE-1:0] w_ready_vec;
    logic [MAX_WARPS_PER_CORE-1:0] w_wait_vec;
    logic [WARP_ID_BITS-1:0]       w_grant;
    logic                          w_grant_valid;
    logic [THREADS_PER_WARP-1:0]   w_grant_mask;
    logic [31:0]                   w_warp_count;
    logic                          w_launch;
    logic                          w_grant_fire;
    logic                          w_exec_fire;

    generate
        for (genvar gi = 0; gi < MAX_WARPS_PER_CORE; gi++) begin : g_warp_vec
            assign w_ready_vec[gi] = (r_status[gi] == READY);
            assign w_wait_vec[gi]  = (r_status[gi] == WAIT_MEM);
        end
        // Lane is live when its global thread index falls below thread_count.
        for (genvar gi = 0; gi < THREADS_PER_WARP; gi++) begin : g_lane_mask
            assign w_grant_mask[gi] = (32'(w_grant) * 32'(THREADS_PER_WARP) + 32'(gi))
                                      < 32'(r_thread_count);
        end
    endgenerate

    warp_rr_arbiter #(
        .N   (MAX_WARPS_PER_CORE),
        .IDW (WARP_ID_BITS)
    ) u_arb (
        .i_req   (w_ready_vec),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_valid (w_grant_valid)
    );

    assign w_warp_count = warps_needed(32'(bus.thread_count), THREADS_PER_WARP,
                                       MAX_WARPS_PER_CORE);
    assign w_launch     = (r_state == IDLE) && bus.start;
    assign w_grant_fire = (r_state == SELECT) && w_grant_valid;
    assign w_exec_fire  = (r_state == EXECUTE) && bus.exec_valid;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic. A launch with thread_count=0 leaves no warp READY, so
    // SELECT falls straight through to DONE on the following edge.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_next = SELECT;
            SELECT: begin
                if (w_grant_valid)    w_state_next = FETCH;
                else if (|w_wait_vec) w_state_next = SELECT;
                else                  w_state_next = DONE;
            end
            FETCH:   if (bus.fetch_ready) w_state_next = EXECUTE;
            EXECUTE: if (bus.exec_valid)  w_state_next = SELECT;
            DONE:    w_state_next = DONE;
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.done            = (r_state == DONE);
        bus.fetch_valid     = (r_state == FETCH);
        bus.fetch_pc        = (r_state == FETCH) ? r_pc[r_cur_warp] : '0;
        bus.current_warp_id = r_cur_warp;
        bus.thread_mask     = r_thread_mask;
    end

    // Per-warp bookkeeping. The issuing warp stays READY while in FETCH/EXECUTE,
    // so a memory response addressed to it is naturally ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_WARPS_PER_CORE; i++) begin
                r_status[i] <= INACTIVE;
                r_pc[i]     <= '0;
            end
            r_rr_ptr       <= '0;
            r_cur_warp     <= '0;
            r_thread_mask  <= '0;
            r_thread_count <= '0;
        end else begin
            if (w_launch) begin
                r_thread_count <= bus.thread_count;
                for (int i = 0; i < MAX_WARPS_PER_CORE; i++) begin
                    r_status[i] <= (i < int'(w_warp_count)) ? READY : INACTIVE;
                    r_pc[i]     <= '0;
                end
            end
            if (w_grant_fire) begin
                r_cur_warp    <= w_grant;
                r_thread_mask <= w_grant_mask;
                r_rr_ptr      <= (w_grant == WARP_ID_BITS'(MAX_WARPS_PER_CORE - 1))
                                 ? '0 : w_grant + 1'b1;
            end
            for (int i = 0; i < MAX_WARPS_PER_CORE; i++) begin
                if (bus.mem_resp_valid && (int'(bus.mem_resp_warp_id) == i)
                    && (r_status[i] == WAIT_MEM))
                    r_status[i] <= READY;
            end
            if (w_exec_fire) begin
                if (bus.decoded_done) begin
                    r_status[r_cur_warp] <= RETIRED;
                end else begin
                    r_pc[r_cur_warp]     <= bus.exec_next_pc;
                    r_status[r_cur_warp] <= (bus.decoded_mem_read_enable ||
                                             bus.decoded_mem_write_enable)
                                            ? WAIT_MEM : READY;
                end
            end
        end
    end

`ifdef WARP_DISPATCHER_PERF_EN
    logic        w_stall;
    logic [31:0] r_perf_issue;
    logic [31:0] r_perf_stall;

    assign w_stall = (r_state == SELECT) && !w_grant_valid && (|w_wait_vec);

    always_ff @(posedge clk) begin
        if (reset || w_launch) begin
            r_perf_issue <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_exec_fire && (r_perf_issue != 32'hFFFF_FFFF))
                r_perf_issue <= r_perf_issue + 32'd1;
            if (w_stall && (r_perf_stall != 32'hFFFF_FFFF))
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign bus.perf_issue_count = r_perf_issue;
    assign bus.perf_stall_count = r_perf_stall;
`else
    assign bus.perf_issue_count = '0;
    assign bus.perf_stall_count = '0;
`endif

endmodule

// File: tb/tb_warp_dispatcher.sv
// Randomized self-checking bench for warp_dispatcher. The bench plays fetcher,
// execute lanes and memory; a warp-level model (status/PC/issue count per warp)
// predicts every grant, PC, lane mask, done and perf value.
`timescale 1ns/1ps
module tb_warp_dispatcher;

    localparam int NW   = 4;
    localparam int TPW  = 4;
    localparam int PCB  = 8;
    localparam int WIDB = 2;

    localparam int S_INACT = 0, S_READY = 1, S_WAIT = 2, S_RET = 3;
    localparam int P_SEL = 0, P_FETCH = 1, P_EXEC = 2;
    localparam int K_ALU = 0, K_MEM = 1, K_RET = 2;

`ifdef WARP_DISPATCHER_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    warp_dispatcher_if #(.PC_BITS(PCB), .THREADS_PER_WARP(TPW), .WARP_ID_BITS(WIDB)) bus ();

    warp_dispatcher #(
        .MAX_WARPS_PER_CORE (NW),
        .THREADS_PER_WARP   (TPW),
        .PC_BITS            (PCB),
        .WARP_ID_BITS       (WIDB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;

    int m_status [NW];
    int m_pc     [NW];
    int m_issues [NW];
    int snap     [NW];
    int mem_cnt  [NW];
    int m_next, m_cur, exp_issue, exp_stall;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [TPW-1:0] mask_of(input int w, input int tc);
        logic [TPW-1:0] m;
        m = '0;
        for (int l = 0; l < TPW; l++)
            if (w * TPW + l < tc) m[l] = 1'b1;
        return m;
    endfunction

    function automatic bit any_of(input int st [NW], input int code);
        for (int w = 0; w < NW; w++)
            if (st[w] == code) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive_idle();
        bus.start                    = 1'b0;
        bus.fetch_ready              = 1'b0;
        bus.exec_valid               = 1'b0;
        bus.exec_next_pc             = '0;
        bus.decoded_done             = 1'b0;
        bus.decoded_mem_read_enable  = 1'b0;
        bus.decoded_mem_write_enable = 1'b0;
        bus.mem_resp_valid           = 1'b0;
        bus.mem_resp_warp_id         = '0;
    endtask

    task automatic check_perf(input string tag);
        check({tag, "_perf_issue"}, 64'(bus.perf_issue_count), PERF_ON ? 64'(exp_issue) : 64'd0);
        check({tag, "_perf_stall"}, 64'(bus.perf_stall_count), PERF_ON ? 64'(exp_stall) : 64'd0);
    endtask

    // One kernel: launch, then serve fetch/execute/memory until done.
    // abort_at >= 0 resets the DUT in EXECUTE of that issue number.
    task automatic run_kernel(input int tc, input int mem_pct, input int fmax, input int emax,
                              input int mdmin, input int mdmax, input int ipw,
                              input int abort_at, input bit skip_reset);
        int n, phase, fd, ed, sel_age, total, exp_w, idx, kind, npc;
        int pend_resp, pend_w, pend_kind, pend_npc, pend_issue, pend_stall;
        bit done_next, finished;

        if (!skip_reset) begin
            reset = 1'b1;
            drive_idle();
            @(negedge clk);
            @(negedge clk);
            reset = 1'b0;
        end
        n = (tc + TPW - 1) / TPW;
        if (n > NW) n = NW;
        for (int w = 0; w < NW; w++) begin
            m_status[w] = (w < n) ? S_READY : S_INACT;
            m_pc[w]     = 0;
            m_issues[w] = 0;
            mem_cnt[w]  = -1;
        end
        m_next = 0; m_cur = 0; exp_issue = 0; exp_stall = 0;
        exp_issue = 0;

        bus.thread_count = 8'(tc);
        bus.start        = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;

        phase = P_SEL; sel_age = 0; total = 0; fd = 0; ed = 0;
        pend_resp = -1; pend_w = -1; pend_kind = K_ALU; pend_npc = 0;
        pend_issue = 0; pend_stall = 0; done_next = 1'b0; finished = 1'b0;

        for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
            // Effects of inputs sampled at the edge just passed; response first,
            // since it sees the pre-edge status.
            if (pend_resp >= 0 && m_status[pend_resp] == S_WAIT) m_status[pend_resp] = S_READY;
            if (pend_w >= 0) begin
                if (pend_kind == K_RET) m_status[pend_w] = S_RET;
                else begin
                    m_pc[pend_w]     = pend_npc;
                    m_status[pend_w] = (pend_kind == K_MEM) ? S_WAIT : S_READY;
                end
            end
            exp_issue += pend_issue;
            exp_stall += pend_stall;
            pend_resp = -1; pend_w = -1; pend_issue = 0; pend_stall = 0;

            check_perf("run");
            if (done_next) begin
                check("done_asserted", 64'(bus.done), 64'd1);
                check("fetch_in_done", 64'(bus.fetch_valid), 64'd0);
                finished = 1'b1;
                break;
            end
            check("done_early", 64'(bus.done), 64'd0);

            if (phase == P_SEL && bus.fetch_valid) begin
                exp_w = -1;
                for (int k = 0; k < NW; k++) begin
                    idx = (m_next + k) % NW;
                    if (exp_w < 0 && snap[idx] == S_READY) exp_w = idx;
                end
                check("grant_expected", 64'(exp_w >= 0), 64'd1);
                if (exp_w >= 0) begin
                    check("grant_warp", 64'(bus.current_warp_id), 64'(exp_w));
                    check("grant_pc", 64'(bus.fetch_pc), 64'(m_pc[exp_w]));
                    check("grant_mask", 64'(bus.thread_mask), 64'(mask_of(exp_w, tc)));
                    m_cur = exp_w;
                end else begin
                    m_cur = int'(bus.current_warp_id);
                end
                m_next = (m_cur + 1) % NW;
                m_issues[m_cur]++;
                total++;
                phase = P_FETCH;
                fd = $urandom_range(0, fmax);
            end else if (phase == P_SEL) begin
                if (sel_age > 0) check("select_no_grant", 64'(any_of(snap, S_READY)), 64'd0);
            end else if (phase == P_FETCH) begin
                check("fetch_hold_valid", 64'(bus.fetch_valid), 64'd1);
                check("fetch_hold_pc", 64'(bus.fetch_pc), 64'(m_pc[m_cur]));
                check("fetch_hold_warp", 64'(bus.current_warp_id), 64'(m_cur));
            end else begin
                check("exec_fetch_low", 64'(bus.fetch_valid), 64'd0);
            end

            if (phase == P_SEL) begin
                if (!any_of(m_status, S_READY)) begin
                    if (any_of(m_status, S_WAIT)) pend_stall = 1;
                    else                          done_next  = 1'b1;
                end
            end
            snap = m_status;

            // Drive inputs for the next edge.
            drive_idle();
            for (int w = 0; w < NW; w++)
                if (mem_cnt[w] > 0) mem_cnt[w]--;
            for (int w = 0; w < NW; w++) begin
                if (pend_resp < 0 && mem_cnt[w] == 0) begin
                    bus.mem_resp_valid   = 1'b1;
                    bus.mem_resp_warp_id = WIDB'(w);
                    mem_cnt[w] = -1;
                    pend_resp  = w;
                end
            end
            if (pend_resp < 0 && ($urandom % 6) == 0) begin
                idx = $urandom % NW;
                if (m_status[idx] != S_WAIT) begin
                    bus.mem_resp_valid   = 1'b1;
                    bus.mem_resp_warp_id = WIDB'(idx);
                    pend_resp = idx;
                end
            end

            case (phase)
                P_FETCH: begin
                    if (fd == 0) begin
                        bus.fetch_ready = 1'b1;
                        phase = P_EXEC;
                        ed = $urandom_range(0, emax);
                    end else begin
                        fd--;
                        bus.exec_valid   = (($urandom % 4) == 0);
                        bus.decoded_done = 1'($urandom);
                    end
                end
                P_EXEC: begin
                    if (abort_at >= 0 && total == abort_at) begin
                        reset = 1'b1;
                        @(negedge clk);
                        check("abort_done", 64'(bus.done), 64'd0);
                        check("abort_fetch_valid", 64'(bus.fetch_valid), 64'd0);
                        check("abort_warp_id", 64'(bus.current_warp_id), 64'd0);
                        check("abort_mask", 64'(bus.thread_mask), 64'd0);
                        exp_issue = 0; exp_stall = 0;
                        check_perf("abort");
                        reset = 1'b0;
                        drive_idle();
                        $display("kernel tc=%0d aborted after %0d issues", tc, total);
                        return;
                    end
                    if (ed == 0) begin
                        npc = int'($urandom % 256);
                        if (m_issues[m_cur] >= ipw) begin
                            kind = K_RET;
                            bus.decoded_done = 1'b1;
                        end else if (int'($urandom % 100) < mem_pct) begin
                            kind = K_MEM;
                            if ($urandom % 2) bus.decoded_mem_read_enable  = 1'b1;
                            else              bus.decoded_mem_write_enable = 1'b1;
                            mem_cnt[m_cur] = $urandom_range(mdmin, mdmax);
                        end else begin
                            kind = K_ALU;
                        end
                        bus.exec_valid   = 1'b1;
                        bus.exec_next_pc = PCB'(npc);
                        pend_w = m_cur; pend_kind = kind; pend_npc = npc; pend_issue = 1;
                        phase = P_SEL;
                        sel_age = 0;
                    end else begin
                        ed--;
                        bus.fetch_ready = (($urandom % 4) == 0);
                    end
                end
                default: begin
                    sel_age++;
                    bus.exec_valid   = (($urandom % 4) == 0);
                    bus.decoded_done = 1'($urandom);
                    bus.fetch_ready  = (($urandom % 4) == 0);
                end
            endcase
            @(negedge clk);
        end
        check("kernel_finished", 64'(finished), 64'd1);
        drive_idle();

        for (int w = 0; w < NW; w++)
            check($sformatf("issues_w%0d", w), 64'(m_issues[w]), (w < n) ? 64'(ipw) : 64'd0);
        check_perf("end");

        // DONE is sticky and start is ignored there.
        bus.thread_count = 8'd8;
        bus.start        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("done_sticky", 64'(bus.done), 64'd1);
            check("done_no_fetch", 64'(bus.fetch_valid), 64'd0);
        end
        bus.start = 1'b0;
        $display("kernel tc=%0d warps=%0d issues=%0d stalls=%0d", tc, n, total, exp_stall);
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();
        bus.thread_count = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_fetch_valid", 64'(bus.fetch_valid), 64'd0);
        check("rst_fetch_pc", 64'(bus.fetch_pc), 64'd0);
        check("rst_warp_id", 64'(bus.current_warp_id), 64'd0);
        check("rst_mask", 64'(bus.thread_mask), 64'd0);
        check("rst_perf_issue", 64'(bus.perf_issue_count), 64'd0);
        check("rst_perf_stall", 64'(bus.perf_stall_count), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        //          tc  mem% fmax emax mdmin mdmax ipw abort skip
        run_kernel( 8,   0,   0,   0,   1,    1,   4,  -1,  0);  // 0,1,0,1... straight line
        run_kernel( 6,   0,   2,   2,   1,    1,   3,  -1,  0);  // partial last warp
        run_kernel( 8,  50,   1,   1,  20,   20,   5,  -1,  0);  // long memory latency
        run_kernel(16, 100,   0,   1,  15,   30,   3,  -1,  0);  // everyone parked -> stalls
        run_kernel( 0,   0,   0,   0,   1,    1,   1,  -1,  0);  // empty launch
        run_kernel(16,  30,   2,   2,   2,   10,   6,   5,  0);  // reset in EXECUTE
        run_kernel(12,  30,   1,   2,   2,   10,   4,  -1,  1);  // restart after abort
        for (int r = 0; r < 4; r++)
            run_kernel($urandom_range(1, 20), $urandom_range(0, 80), 3, 3, 1, 12,
                       $urandom_range(1, 6), -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
